// File: rtl/vga_text_pkg.sv
// Shared constants, types and address helper for the 80x60 VGA text display path.
package vga_text_pkg;

    localparam int unsigned H_SYNC        = 96;
    localparam int unsigned H_ACT_START   = 144;
    localparam int unsigned H_ACT_END     = 784;
    localparam int unsigned H_TOTAL       = 800;
    localparam int unsigned V_SYNC        = 2;
    localparam int unsigned V_ACT_START   = 35;
    localparam int unsigned V_ACT_END     = 515;
    localparam int unsigned V_TOTAL       = 525;

    // Fetch slots run one cell (8 pixels) ahead of the displayed cell.
    localparam int unsigned H_FETCH_START = H_ACT_START - 8;
    localparam int unsigned H_FETCH_END   = H_ACT_END - 8;

    localparam int unsigned COLS          = 80;
    localparam int unsigned ROWS          = 60;
    localparam int unsigned CELLS         = 4800;

    localparam int unsigned TADDR_W       = 13;
    localparam int unsigned FADDR_W       = 10;
    localparam int unsigned HCNT_W        = 10;
    localparam int unsigned VCNT_W        = 10;
    localparam int unsigned CODE_W        = 8;
    localparam int unsigned RGB_W         = 3;
    localparam int unsigned ROW_W         = 6;
    localparam int unsigned COL_W         = 7;

    localparam logic [RGB_W-1:0] FG_RGB   = 3'b111;
    localparam logic [RGB_W-1:0] BG_RGB   = 3'b000;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_ACK  = 1'b1
    } arb_state_t;

    // row*80 + col built from shifts: row*64 + row*16 + col.
    function automatic logic [TADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return (TADDR_W'(row) << 6) + (TADDR_W'(row) << 4) + TADDR_W'(col);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480 timing from a 4-phase pixel enable: counters, registered syncs,
// active-area and fetch-slot/shift-load qualifiers.
module vga_timing_gen
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              pix_ce,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              active_c,
    output logic              fetch_slot_c,
    output logic              load_c
);

    logic [1:0] ph;
    logic       h_act;
    logic       v_act;

    // Syncs are registered from the pre-increment counters, alongside the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph     <= '0;
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end else begin
            ph <= ph + 2'd1;
            if (pix_ce) begin
                hsync <= (hcount < HCNT_W'(H_SYNC));
                vsync <= (vcount < VCNT_W'(V_SYNC));
                if (hcount == HCNT_W'(H_TOTAL - 1)) begin
                    hcount <= '0;
                    vcount <= (vcount == VCNT_W'(V_TOTAL - 1)) ? '0 : vcount + VCNT_W'(1);
                end else begin
                    hcount <= hcount + HCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        pix_ce       = (ph == 2'd3);
        h_act        = (hcount >= HCNT_W'(H_ACT_START)) && (hcount < HCNT_W'(H_ACT_END));
        v_act        = (vcount >= VCNT_W'(V_ACT_START)) && (vcount < VCNT_W'(V_ACT_END));
        active_c     = h_act && v_act;
        fetch_slot_c = v_act && (ph == 2'd0) && (hcount[2:0] == 3'd0)
                       && (hcount >= HCNT_W'(H_FETCH_START))
                       && (hcount <= HCNT_W'(H_FETCH_END));
        // Load at the last pixel of each cell so the next cell starts on a boundary.
        load_c       = pix_ce && v_act && (hcount[2:0] == 3'd7)
                       && (hcount >= HCNT_W'(H_ACT_START - 1))
                       && (hcount < HCNT_W'(H_ACT_END - 8));
    end

endmodule

// File: rtl/vga_text_scheduler.sv
// Text-mode VGA scheduler: per-cell text/font fetch, pixel shifter, and a
// write arbiter sharing the text-RAM port with display-fetch priority.
module vga_text_scheduler
    import vga_text_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [TADDR_W-1:0] wr_addr,
    input  logic [CODE_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic [TADDR_W-1:0] tram_addr,
    output logic               tram_rd,
    output logic               tram_we,
    output logic [CODE_W-1:0]  tram_wdata,
    input  logic [CODE_W-1:0]  tram_rdata,
    output logic [FADDR_W-1:0] font_addr,
    input  logic [CODE_W-1:0]  font_rdata,
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   disp_RGB
);

    logic              pix_ce;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              active_c;
    logic              fetch_slot_c;
    logic              load_c;

    logic [VCNT_W-1:0]  gy;
    logic [HCNT_W-1:0]  hoff;
    logic [ROW_W-1:0]   fetch_row;
    logic [COL_W-1:0]   fetch_col;
    logic [2:0]         glyph_row;
    logic [TADDR_W-1:0] fetch_addr;

    logic              fetch_s1;
    logic              fetch_s2;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] next_row;
    logic              next_inv;
    logic [CODE_W-1:0] shreg;
    logic              cur_inv;

    arb_state_t state_q;
    arb_state_t state_d;
    logic       take_c;

    vga_timing_gen u_tg (
        .clk          (clk),
        .rst          (rst),
        .pix_ce       (pix_ce),
        .hcount       (hcount),
        .vcount       (vcount),
        .hsync        (hsync),
        .vsync        (vsync),
        .active_c     (active_c),
        .fetch_slot_c (fetch_slot_c),
        .load_c       (load_c)
    );

    // Cell/glyph coordinates; font address follows RAM data directly in phase 1.
    always_comb begin
        gy         = vcount - VCNT_W'(V_ACT_START);
        hoff       = hcount - HCNT_W'(H_FETCH_START);
        fetch_row  = ROW_W'(gy >> 3);
        glyph_row  = 3'(gy);
        fetch_col  = COL_W'(hoff >> 3);
        fetch_addr = cell_addr(fetch_row, fetch_col);
        font_addr  = {(fetch_s1 ? tram_rdata[6:0] : code[6:0]), glyph_row};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_s1 <= 1'b0;
            fetch_s2 <= 1'b0;
            code     <= '0;
            next_row <= '0;
            next_inv <= 1'b0;
            shreg    <= '0;
            cur_inv  <= 1'b0;
            disp_RGB <= '0;
        end else begin
            fetch_s1 <= fetch_slot_c;
            fetch_s2 <= fetch_s1;
            if (fetch_s1) begin
                code <= tram_rdata;
            end
            if (fetch_s2) begin
                next_row <= font_rdata;
                next_inv <= code[7];
            end
            // Inverse flag is captured with the row so it cannot change mid-cell.
            if (pix_ce) begin
                disp_RGB <= active_c ? ((shreg[7] ^ cur_inv) ? FG_RGB : BG_RGB) : '0;
                if (load_c) begin
                    shreg   <= next_row;
                    cur_inv <= next_inv;
                end else begin
                    shreg <= {shreg[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            wr_ack  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ack  <= take_c;
        end
    end

    // Arbiter and port mux: a fetch slot always owns the port for its clk.
    always_comb begin
        state_d    = state_q;
        take_c     = 1'b0;
        tram_rd    = 1'b0;
        tram_we    = 1'b0;
        tram_addr  = fetch_addr;
        tram_wdata = wr_data;
        case (state_q)
            ARB_IDLE: begin
                if (wr_req && !fetch_slot_c && !rst) begin
                    take_c  = 1'b1;
                    state_d = ARB_ACK;
                end
            end
            ARB_ACK:  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (fetch_slot_c) begin
            tram_rd = 1'b1;
        end else if (take_c) begin
            tram_addr = wr_addr;
            tram_we   = (wr_addr < TADDR_W'(CELLS));
        end
    end

endmodule

// File: tb/tb_vga_text_scheduler.sv
// Directed bench for vga_text_scheduler with text-RAM/font-ROM models and a
// pixel scoreboard derived from the bench's own copy of the screen contents.
module tb_vga_text_scheduler;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [12:0] tram_addr;
    logic        tram_rd;
    logic        tram_we;
    logic [7:0]  tram_wdata;
    logic [7:0]  tram_rdata;
    logic [9:0]  font_addr;
    logic [7:0]  font_rdata;
    logic        hsync;
    logic        vsync;
    logic [2:0]  disp_RGB;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem     [0:4799];
    logic [7:0]  ref_mem [0:4799];
    logic        fill_go;
    logic [7:0]  fill_code;
    logic [31:0] exp_q [$];

    vga_text_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .tram_addr  (tram_addr),
        .tram_rd    (tram_rd),
        .tram_we    (tram_we),
        .tram_wdata (tram_wdata),
        .tram_rdata (tram_rdata),
        .font_addr  (font_addr),
        .font_rdata (font_rdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .disp_RGB   (disp_RGB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font_of(input logic [6:0] c);
        return (c == 7'h33) ? 8'h3C : 8'hA5;
    endfunction

    // Text RAM and font ROM, both with one clock of read latency.
    always @(posedge clk) begin
        if (fill_go) begin
            for (int i = 0; i < 4800; i++) mem[i] <= fill_code;
        end else if (tram_we && tram_addr < 13'd4800) begin
            mem[tram_addr] <= tram_wdata;
        end
        if (tram_rd) tram_rdata <= (tram_addr < 13'd4800) ? mem[tram_addr] : 8'h00;
        font_rdata <= font_of(7'(font_addr >> 3));
    end

    function automatic logic [2:0] exp_pix(input int v, input int h);
        int row, col, bitn;
        logic [7:0] c, f;
        if (h < 144 || h >= 784 || v < 35 || v >= 515) return 3'd0;
        row  = (v - 35) / 8;
        col  = (h - 144) / 8;
        bitn = 7 - ((h - 144) % 8);
        c    = ref_mem[row * 80 + col];
        f    = font_of(c[6:0]);
        return (f[bitn] ^ c[7]) ? 3'b111 : 3'b000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hsync_rise(output logic ok);
        logic prev;
        ok   = 1'b0;
        prev = hsync;
        for (int i = 0; i < 3400; i++) begin
            step();
            if (!prev && hsync) begin
                ok = 1'b1;
                break;
            end
            prev = hsync;
        end
    endtask

    // Sample k*4 clks after the hsync rise corresponds to hcount k.
    task automatic check_line(input string tag, input int v);
        logic ok;
        wait_hsync_rise(ok);
        check({tag, "_sync"}, 32'(ok), 32'd1);
        for (int h = 136; h < 792; h++) exp_q.push_back(32'(exp_pix(v, h)));
        for (int h = 1; h < 792; h++) begin
            repeat (4) step();
            if (h >= 136) check(tag, 32'(disp_RGB), exp_q.pop_front());
        end
    endtask

    task automatic set_all(input logic [7:0] c);
        for (int i = 0; i < 4800; i++) ref_mem[i] = c;
        fill_code = c;
        fill_go   = 1'b1;
        step();
        fill_go   = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        logic prev;
        int   hi, vhi, cnt;

        rst     = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 4800; i++) ref_mem[i] = 8'h41;
        fill_code = 8'h41;
        fill_go   = 1'b1;
        repeat (3) step();
        fill_go   = 1'b0;

        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_disp", 32'(disp_RGB), 32'd0);
        check("rst_ack", 32'(wr_ack), 32'd0);
        check("rst_rd", 32'(tram_rd), 32'd0);
        check("rst_we", 32'(tram_we), 32'd0);
        rst = 1'b0;

        // One line: hsync high 96 pixel periods, period 800 pixels.
        wait_hsync_rise(ok);
        check("hsync_start", 32'(ok), 32'd1);
        hi  = 0;
        vhi = 0;
        for (int i = 0; i < 3200; i++) begin
            if (hsync) hi++;
            if (vsync) vhi++;
            step();
        end
        check("hsync_width", 32'(hi), 32'd384);
        check("line0_vsync", 32'(vhi), 32'd3200);
        check("hsync_period", 32'(hsync), 32'd1);

        // Jump near frame end to see vsync span lines 0 and 1.
        step();
        force dut.u_tg.vcount = 10'd523;
        step();
        release dut.u_tg.vcount;
        ok   = 1'b0;
        prev = vsync;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (!prev && vsync) begin
                ok = 1'b1;
                break;
            end
            prev = vsync;
        end
        check("vsync_rise", 32'(ok), 32'd1);
        cnt = 0;
        for (int i = 0; i < 7000 && vsync; i++) begin
            cnt++;
            step();
        end
        check("vsync_width", 32'(cnt), 32'd6400);
        check("vsync_hsync_align", 32'(hsync), 32'd1);

        // Glyph pattern and inverse video on the first two active lines.
        step();
        force dut.u_tg.vcount = 10'd34;
        step();
        release dut.u_tg.vcount;
        check_line("glyph", 35);
        set_all(8'hC1);
        check_line("inverse", 36);
        set_all(8'h41);

        // Write requested on a fetch-slot clk.
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (tram_rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("slot_found", 32'(ok), 32'd1);
        wr_req  = 1'b1;
        wr_addr = 13'd81;
        wr_data = 8'h33;
        ref_mem[81] = 8'h33;
        #1;
        check("coll_rd", 32'(tram_rd), 32'd1);
        check("coll_we_blocked", 32'(tram_we), 32'd0);
        check("coll_fetch_addr", 32'(tram_addr), 32'd0);
        step();
        check("coll_we", 32'(tram_we), 32'd1);
        check("coll_rd_off", 32'(tram_rd), 32'd0);
        check("coll_addr", 32'(tram_addr), 32'd81);
        check("coll_wdata", 32'(tram_wdata), 32'h33);
        check("coll_ack_early", 32'(wr_ack), 32'd0);
        step();
        check("coll_ack", 32'(wr_ack), 32'd1);
        check("coll_we_done", 32'(tram_we), 32'd0);
        wr_req = 1'b0;
        step();
        check("coll_ack_pulse", 32'(wr_ack), 32'd0);

        // Row 1 (vcount 43) shows glyph 0x33 at column 1.
        step();
        force dut.u_tg.vcount = 10'd42;
        step();
        release dut.u_tg.vcount;
        check_line("coll_cell", 43);

        // Out-of-range write: acked, never written.
        step();
        wr_req  = 1'b1;
        wr_addr = 13'd4800;
        wr_data = 8'h55;
        #1;
        check("oor_we_take", 32'(tram_we), 32'd0);
        step();
        check("oor_ack", 32'(wr_ack), 32'd1);
        check("oor_we_ack", 32'(tram_we), 32'd0);
        wr_req = 1'b0;
        step();
        check("oor_ack_pulse", 32'(wr_ack), 32'd0);

        // Held request: one write then one ack, alternating.
        wr_addr = 13'd5;
        wr_data = 8'h41;
        wr_req  = 1'b1;
        for (int k = 0; k < 12; k++) exp_q.push_back((k % 2 == 1) ? 32'd2 : 32'd1);
        #1;
        for (int k = 0; k < 12; k++) begin
            check("btb_ack_we", 32'({wr_ack, tram_we}), exp_q.pop_front());
            if (k == 11) wr_req = 1'b0;
            step();
        end

        // Reset mid-line with a pending request.
        repeat (2000) step();
        wr_req  = 1'b1;
        wr_addr = 13'd10;
        wr_data = 8'h41;
        rst     = 1'b1;
        #1;
        check("mid_rst_hsync", 32'(hsync), 32'd0);
        check("mid_rst_vsync", 32'(vsync), 32'd0);
        check("mid_rst_disp", 32'(disp_RGB), 32'd0);
        check("mid_rst_ack", 32'(wr_ack), 32'd0);
        check("mid_rst_rd", 32'(tram_rd), 32'd0);
        check("mid_rst_we", 32'(tram_we), 32'd0);
        step();
        step();
        check("rst_hold_ack", 32'(wr_ack), 32'd0);
        check("rst_hold_we", 32'(tram_we), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_we", 32'(tram_we), 32'd1);
        check("post_rst_addr", 32'(tram_addr), 32'd10);
        for (int k = 1; k <= 4; k++) exp_q.push_back((k == 4) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) begin
                check("post_rst_ack", 32'(wr_ack), 32'd1);
                wr_req = 1'b0;
            end
            check("post_rst_hsync", 32'(hsync), exp_q.pop_front());
        end
        check("post_rst_vsync", 32'(vsync), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_text_scheduler.md
# vga_text_scheduler

Sequences an 80×60 character VGA display built from 8×8 glyphs, and is the text-RAM owner at the top of the VGA path. It generates 640×480 timing from the 100 MHz system clock. Per character cell, it fetches a character code from an external text RAM and the matching glyph row from an external font ROM, then shifts the pixels out to `disp_RGB`. It also shares the single text-RAM port with one write requester, using a req/ack handshake and giving the display fetch fixed priority.

## Interface
- `FG_RGB`, 3'b111, foreground colour
- `BG_RGB`, 3'b000, background colour
- `clk`  in  1  100 MHz system clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_req`  in  1  write request; held until `wr_ack`
- `wr_addr`  in  13  cell address, row*80+col
- `wr_data`  in  8  character code
- `wr_ack`  out  1  one-cycle pulse; write completed or dropped
- `tram_addr`  out  13  text-RAM address
- `tram_rd`  out  1  text-RAM read strobe; data valid next clk
- `tram_we`  out  1  text-RAM write strobe
- `tram_wdata`  out  8  text-RAM write data
- `tram_rdata`  in  8  text-RAM read data, 1-clk latency
- `font_addr`  out  10  {code[6:0], glyph_row[2:0]}
- `font_rdata`  in  8  glyph row, 1-clk latency, bit 7 = leftmost pixel
- `hsync`, `vsync`  out  1 each  active-high sync
- `disp_RGB`  out  3  pixel colour

One clock; reset is asynchronous and active-high.

## Operation
- **Pixel clock:** 2-bit phase counter `ph` increments every clk. `pix_ce` is asserted when `ph==3`, giving 25 MHz.
- **Horizontal counter:** `hcount` runs 0..799.
- **Vertical counter:** `vcount` runs 0..524 and advances on the `pix_ce` where `hcount==799`.
- **Sync:** `hsync` = `hcount<96`; `vsync` = `vcount<2`.
- **Active area:** `hcount` 144..783 and `vcount` 35..514.
- **Cell coordinates:**
  - `gy = vcount-35`; cell row = `gy>>3`; glyph row = `gy[2:0]`.
  - Cells are aligned to `hcount%8==0`.
- **Fetch slot:**
  - A fetch slot exists when `vcount` is active, `hcount` is in 136..776, `hcount%8==0`, and `ph==0`.
  - The slot fetches column `(hcount-136)>>3`, i.e. the cell displayed in the next 8 pixels.
  - The address is formed as (row<<6)+(row<<4)+col; no multiplier.
- **Fetch pipeline:**
  - ph0: `tram_rd=1` and `tram_addr` is set.
  - ph1: `tram_rdata` is latched into `code`, and `font_addr` is driven.
  - ph2: `font_rdata` is latched into `next_row`, and `code[7]` is latched into `next_inv`.
- **Shift register:**
  - On the `pix_ce` ending `hcount%8==7` inside the active area, `next_row` loads into the shift register; otherwise it shifts left by one.
  - Pixel colour is `FG_RGB` if the bit is 1, else `BG_RGB`. When `next_inv` is set, the two colours are swapped.
  - Outside the active area, `disp_RGB` = 0.
- **Write arbiter FSM:**
  - States: IDLE, ACK.
  - IDLE→ACK when `wr_req` is high and the current clk is not a fetch slot. On that cycle: `tram_addr=wr_addr`, `tram_wdata=wr_data`, and `tram_we=1` if `wr_addr<4800`.
  - ACK→IDLE unconditionally. `wr_ack=1` during ACK.
  - `wr_req` is ignored while in ACK.
- **Collision:** if `wr_req` arrives in a fetch slot, the display wins and the write is taken on the next clk.
- **Out-of-range writes:** when `wr_addr>=4800`, `wr_ack` still pulses but `tram_we` stays 0.

## Timing
- **Reset:**
  - `ph`, `hcount`, `vcount` = 0.
  - `hsync`, `vsync`, `disp_RGB`, `wr_ack`, `tram_rd`, `tram_we` = 0.
  - Shift register and `next_row` = 0; FSM in IDLE.
- **Reset mid-operation:** the pending write is lost without ack, and the requester must keep `wr_req` high.
- **Output registers:** `hsync`, `vsync` and `disp_RGB` are registered together on `pix_ce` from the pre-increment counter values, so sync and pixel stay aligned.
- **Fetch slack:** each fetch completes 2 clks after its slot, well before the load edge 29 clks later.
- **Write latency:** `wr_ack` arrives 1 clk after `wr_req` with no collision, or 2 clks after a collision. Throughput is one write per 2 clks.
- **Port driving:** `tram_rd` and `tram_we` are never high in the same clk. `tram_rd`, `tram_we` and `tram_addr` are combinational from the registered state and phase.

## Structure
- **Package `vga_text_pkg`:**
  - Timing constants: 96, 144, 784, 800, 2, 35, 515, 525.
  - `COLS=80`, `ROWS=60`, `CELLS=4800`.
  - `TADDR_W=13`, `FADDR_W=10`.
  - Arbiter state enum.
- **Sub-module `vga_timing_gen`:** contains `ph`, `pix_ce`, the counters, sync generation and the active/fetch-slot flags. The fetch pipeline, shifter and arbiter stay in the top level.

## Test plan
- **Reset then free-run:** over one frame, `hsync` is high 96 of every 800 `pix_ce` periods, `vsync` is high 2 of 525 lines, and the frame is exactly 1,680,000 clks.
- **Glyph output:** model the RAM with every cell = 0x41 and the font row = 8'hA5. Active pixels follow 1,0,1,0,0,1,0,1 as 7,0,7,0,0,7,0,7. The first active pixel appears at `hcount` 144.
- **Inverse video:** with code 0xC1 and the same font row, the pixels are inverted: 0,7,0,7,7,0,7,0.
- **Write collision:** assert `wr_req` (addr 81, data 0x33) on a fetch-slot clk. `tram_rd` wins that clk, `tram_we` is high the next clk at addr 81, and `wr_ack` follows 1 clk later. The cell at row 1, col 1 then displays glyph 0x33.
- **Out-of-range write:** `wr_addr`=4800 gives a `wr_ack` pulse with `tram_we` never high.
- **Back-to-back writes:** holding `wr_req` yields one ack every 2 clks. Asserting `rst` mid-line zeroes all outputs immediately, and the counters restart at 0.
